// File: rtl/alu_arbiter.sv
// Two-client arbiter/sequencer in front of a shared combinational ALU.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (client 0) otherwise.
module alu_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*OPW-1:0]   req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_res,
  output logic               rsp_zero,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_op,
  input  logic [WIDTH-1:0]   alu_res,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             id_q, zero_q;
  logic [1:0]       grant;
  logic             accept;
  logic             win;

`ifdef ALU_ARB_RR_EN
  logic ptr_q;

  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= ~win;
    end
  end
`else
  always_comb begin
    grant = {req_valid[1] & ~req_valid[0], req_valid[0]};
  end
`endif

  assign win    = grant[1];
  assign accept = (state_q == StIdle) && (grant != 2'b00);

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        // Keep req_ready low while reset is held so every output reads zero.
        req_ready = reset_n ? grant : 2'b00;
        if (grant != 2'b00) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q <= win ? req_op[OPW +: OPW]   : req_op[0 +: OPW];
        a_q  <= win ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        b_q  <= win ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
        id_q <= win;
      end
      if (state_q == StExec) begin
        res_q  <= alu_res;
        zero_q <= alu_zero;
      end
    end
  end

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign rsp_id   = id_q;
  assign rsp_res  = res_q;
  assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned OPW   = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*OPW-1:0]   req_op;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_res;
  logic               rsp_zero;
  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [OPW-1:0]     alu_op;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_zero;
  logic               busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .busy      (busy)
  );

  // Behavioural adder standing in for the ALU.
  assign alu_res  = alu_a + alu_b;
  assign alu_zero = (alu_res == '0);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) check("onehot_ready", 32'($countones(req_ready) <= 1), 32'd1);

  // Transaction-level model: one outstanding operation at a time.
  logic             m_busy, m_id, m_ptr, m_zero;
  int               m_age;
  logic [OPW-1:0]   m_op;
  logic [WIDTH-1:0] m_a, m_b, m_res;
  int               cyc;
  int               grant_log[$];
  int               acc_cyc[$];

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic p);
`ifdef ALU_ARB_RR_EN
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
`else
    if (v == 2'b11) return 2'b01;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_id = 1'b0; m_ptr = 1'b0; m_zero = 1'b0; m_age = 0;
    m_op = '0; m_a = '0; m_b = '0; m_res = '0;
  endtask

  task automatic cycle();
    logic [1:0]       g;
    logic             rr;
    int               w;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a, b;
    @(negedge clk);
    g  = 2'b00;
    rr = rsp_ready;
    if (!m_busy) begin
      g = model_grant(req_valid, m_ptr);
      check("req_ready_idle", 32'(req_ready), 32'(g));
      check("busy_idle", 32'(busy), 32'd0);
      check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
    end else begin
      check("req_ready_busy", 32'(req_ready), 32'd0);
      check("busy", 32'(busy), 32'd1);
      check("rsp_valid", 32'(rsp_valid), 32'(m_age >= 1));
      if (m_age >= 1) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_res", rsp_res, m_res);
        check("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      end
    end
    check("alu_a", alu_a, m_a);
    check("alu_b", alu_b, m_b);
    check("alu_op", 32'(alu_op), 32'(m_op));
    w  = g[1] ? 1 : 0;
    op = req_op[w*OPW +: OPW];
    a  = req_a[w*WIDTH +: WIDTH];
    b  = req_b[w*WIDTH +: WIDTH];
    @(posedge clk);
    cyc++;
    if (m_busy) begin
      if (m_age >= 1 && rr) m_busy = 1'b0;
      else m_age = 1;
    end else if (g != 2'b00) begin
      m_busy = 1'b1; m_age = 0; m_id = g[1];
      m_op = op; m_a = a; m_b = b;
      m_res = a + b; m_zero = (m_res == '0);
      m_ptr = ~g[1];
      grant_log.push_back(w);
      acc_cyc.push_back(cyc);
    end
    #1;
  endtask

  task automatic set_req(input int c, input logic [OPW-1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_op[c*OPW +: OPW]     = op;
    req_a[c*WIDTH +: WIDTH]  = a;
    req_b[c*WIDTH +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, "_rsp_res"}, rsp_res, 32'd0);
    check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, "_alu_a"}, alu_a, 32'd0);
    check({tag, "_alu_b"}, alu_b, 32'd0);
    check({tag, "_alu_op"}, 32'(alu_op), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] snap_res;
    logic             snap_id;
    int               exp_ids[4];
    cyc = 0;
    model_reset();
    reset_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    check_all_zero("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: reset mid-EXEC, then 5+7 from client 0.
    req_valid = 2'b01; set_req(0, 4'h2, 32'd5, 32'd7);
    cycle();
    check("s1_in_exec", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midexec_reset");
    model_reset();
    #1;
    reset_n = 1'b1;
    cycle();
    req_valid = 2'b00;
    cycle();
    check("s1_rsp_valid", 32'(rsp_valid), 32'd1);
    check("s1_rsp_res", rsp_res, 32'd12);
    check("s1_rsp_zero", 32'(rsp_zero), 32'd0);
    check("s1_rsp_id", 32'(rsp_id), 32'd0);
    cycle(); cycle();

    // 2: client 1 alone, wrap to zero.
    req_valid = 2'b10; set_req(1, 4'h2, 32'hFFFF_FFFF, 32'd1);
    cycle();
    req_valid = 2'b00;
    cycle();
    check("s2_rsp_res", rsp_res, 32'd0);
    check("s2_rsp_zero", 32'(rsp_zero), 32'd1);
    check("s2_rsp_id", 32'(rsp_id), 32'd1);
    cycle(); cycle();

    // 3/4: both clients continuously valid, rsp_ready held high.
    do_reset();
    grant_log.delete(); acc_cyc.delete();
    set_req(0, 4'h1, 32'd10, 32'd20); set_req(1, 4'h3, 32'd100, 32'd200);
    req_valid = 2'b11; rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
`ifdef ALU_ARB_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    check("s3_accepts", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("s3_grant", 32'(grant_log[i]), 32'(exp_ids[i]));
      for (int i = 0; i < 3; i++) check("s3_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) cycle();

    // 5: response stall for 10 cycles; client 0 waits meanwhile.
    req_valid = 2'b01; set_req(0, 4'h5, 32'h1234_5678, 32'h1111_1111); rsp_ready = 1'b0;
    cycle(); cycle();
    snap_res = rsp_res; snap_id = rsp_id;
    for (int i = 0; i < 10; i++) cycle();
    check("s5_res_stable", rsp_res, snap_res);
    check("s5_id_stable", 32'(rsp_id), 32'(snap_id));
    check("s5_res_value", rsp_res, 32'h2345_6789);
    rsp_ready = 1'b1;
    // 6: client 0 drops exactly as client 1 raises.
    cycle();
    check("s5_idle_after", 32'(busy), 32'd0);
    req_valid = 2'b10; set_req(1, 4'h7, 32'd3, 32'd4);
    grant_log.delete();
    cycle();
    check("s6_grant_count", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) check("s6_grant", 32'(grant_log[0]), 32'd1);
    req_valid = 2'b00;
    cycle(); cycle();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int c = 0; c < 2; c++) begin
        logic [WIDTH-1:0] ra;
        ra = $urandom;
        set_req(c, 4'($urandom), ra, ($urandom_range(0, 3) == 0) ? -ra : $urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
